// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and transfer decode helpers
// for the data-side SRAM slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_e;

    // Oversized or misaligned transfers are answered with an ERROR response.
    function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = a[0];
            HSIZE_WORD: bad = (a != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian byte-lane enables for a legal transfer.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'(4'b0001 << a);
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read, no reset.
module ahb_sram_array #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_data_sram_slave.sv
// AHB-Lite data-side SRAM slave: address-phase capture, wait-state counter,
// byte-lane write decode and two-cycle ERROR response for illegal transfers.
module ahb_data_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned AQ_W  = ADDR_WIDTH + 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic              valid_c;
    logic              accept_ok_c;
    logic [3:0]        be_c;
    logic [31:0]       rdata_c;
    logic              unused_c;

    assign valid_c  = HSEL & HTRANS[1] & HREADY;
    assign unused_c = ^{HADDR[31:AQ_W], HTRANS[0]};

    // Next-state, wait counter, address-phase capture and write-commit decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        accept_ok_c = 1'b0;
        be_c        = 4'b0000;

        case (state_q)
            ST_IDLE: accept_ok_c = 1'b1;
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    accept_ok_c = 1'b1;
                    if (write_q) begin
                        be_c = lane_enables(size_q, addr_q[1:0]);
                    end
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: accept_ok_c = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        if (accept_ok_c) begin
            state_d = ST_IDLE;
            if (valid_c) begin
                addr_d  = HADDR[AQ_W-1:0];
                write_d = HWRITE;
                size_d  = HSIZE;
                if (size_illegal(HSIZE, HADDR[1:0])) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    ahb_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (HCLK),
        .addr  (addr_q[AQ_W-1:2]),
        .be    (be_c),
        .wdata (HWDATA),
        .rdata (rdata_c)
    );

    // Responses are pure decodes of the state flops.
    assign HREADYOUT = !((state_q == ST_ERR1) || ((state_q == ST_DATA) && (cnt_q != '0)));
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? rdata_c : 32'h0;

endmodule

// File: doc/ahb_data_sram_slave.md
Name: ahb_data_sram_slave

Overview:
AHB-Lite slave: word-organised data SRAM on the processor's data-side AHB bus (HADDRD/HTRANSD/HWRITED/HSIZED/HWDATAD in, HRDATAD/HREADYOUTD/HRESPD out).
Configurable wait states exercise the master's stall/hold logic; byte/halfword/word writes via byte-lane enables; unaligned/illegal-size transfers get a two-cycle ERROR response.

Parameters:
ADDR_WIDTH, 12, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words; HADDR[ADDR_WIDTH+1:2] indexes, upper bits ignored (aliasing).
WAIT_STATES, 1, extra data-phase cycles per OKAY transfer, legal 0..7.

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address, address phase
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write, address phase
HSIZE  in  3  000 byte, 001 half, 010 word; others illegal
HWDATA  in  32  write data, data phase
HREADY  in  1  bus ready; tie to HREADYOUT in single-slave systems
HRDATA  out  32  read data, valid when HREADYOUT=1 in read data phase
HREADYOUT  out  1  0 = extend current data phase
HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (HRESETn low, async, also mid-transfer): state IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0; pending write discarded; array contents not reset.
- Accept: valid = HSEL & HTRANS[1] & HREADY; on accept register addr_q, write_q, size_q. IDLE/BUSY transfers with HSEL: zero-wait OKAY, no state change.
- Error check at accept: HSIZE>010, half with HADDR[0]=1, word with HADDR[1:0]!=00 -> ERR1.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. valid&legal -> DATA, cnt=WAIT_STATES; valid&illegal -> ERR1.
- DATA: HREADYOUT=(cnt==0), HRESP=0; cnt decrements while >0. At cnt==0 transfer completes: write commits byte lanes at this edge; read data presented this cycle. Same-cycle new accept -> DATA (reload cnt) or ERR1; else IDLE.
- ERR1: HREADYOUT=0, HRESP=1; -> ERR2 unconditionally. No array access.
- ERR2: HREADYOUT=1, HRESP=1; accepts new transfer exactly as IDLE, else -> IDLE.
- Byte lanes little-endian: byte -> lane addr_q[1:0]; half -> lanes {addr_q[1],0}/{addr_q[1],1}; word -> all four. Write data taken from matching HWDATA lanes.
- Reads: HRDATA = array[addr_q word] (asynchronous array read) during read data phase; full word regardless of size; HRDATA=0 outside read data phases.
- Read-after-write: write commits at edge ending its data phase, so a pipelined read of same word returns new data, no forwarding.
- Latency: OKAY data phase = 1+WAIT_STATES cycles; ERROR = 2 cycles.
- HWDATA/HSEL changes while HREADYOUT=0 in DATA ignored except HWDATA sampled at cnt==0.

Decomposition:
- Shared defines/package ahb_pkg: HTRANS codes, HSIZE codes, HRESP codes, state encoding (2 bits).
- Sub-module ahb_sram_array: 2**ADDR_WIDTH x 32, 4-bit byte-enable synchronous write, asynchronous read, no reset.
- Top holds FSM, wait counter, address-phase registers, lane-enable decode, error check.

Test Plan:
1. Reset asserted mid-DATA wait (WAIT_STATES=3, cnt=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; no write to array.
2. WAIT_STATES=1: word write 0xDEADBEEF @0x10, then read @0x10 -> each data phase HREADYOUT low 1 cycle, read HRDATA=0xDEADBEEF, HRESP=0.
3. Byte write HWDATA=0x0000AA00 @0x11 over 0xDEADBEEF, then half write 0x12340000 @0x12 -> read @0x10 = 0x1234AAEF.
4. Word write @0x13 -> ERR1 (HREADYOUT=0, HRESP=1), ERR2 (1,1); HSIZE=011 @0x20 same response; read @0x10 unchanged.
5. WAIT_STATES=0 pipelined: write 0xCAFEF00D @0x20, next cycle read @0x20 -> HREADYOUT stays 1, HRDATA=0xCAFEF00D.
6. ADDR_WIDTH=12: write 0x11111111 @0x4000 -> read @0x0000 = 0x11111111 (alias); IDLE/BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, no state change.
